// File: rtl/tdm_demux_16.sv
// -----------------------------------------------------------------------------
// tdm_demux_16
// Receive end of the 16-channel TDM path. A 1-bit serial stream carrying one
// slot per accepted beat is collected into a shadow frame. A complete frame is
// then released on q as a single update, marked by a one-cycle q_valid pulse.
//
// Optional feature: define DEMUX_PARITY_EN to append one even-parity beat to
// every frame. A frame whose parity check fails is dropped with frame_err.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   din        in   1   serial data bit for the current slot
//   din_valid  in   1   a beat is accepted on the clock edge while high
//   sof        in   1   start-of-frame (qualified by din_valid), marks slot 0
//   q          out  16  last complete frame, q[k] = bit received in slot k
//   q_valid    out  1   one-cycle pulse: q was updated this cycle
//   slot       out  4   slot the next accepted bit will be written to
//   busy       out  1   a frame is partially collected
//   frame_err  out  1   one-cycle pulse: frame aborted (early sof / parity fail)
// -----------------------------------------------------------------------------
module tdm_demux_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        sof,
    output logic [15:0] q,
    output logic        q_valid,
    output logic [3:0]  slot,
    output logic        busy,
    output logic        frame_err
);

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

`ifdef DEMUX_PARITY_EN
    typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

    state_t            state,      state_nxt;
    logic [N_CH-1:0]   shadow,     shadow_nxt;
    logic [N_CH-1:0]   q_nxt;
    logic [SEL_W-1:0]  slot_nxt;
    logic              q_valid_nxt;
    logic              busy_nxt;
    logic              frame_err_nxt;

    // Every register is reset, including the shadow frame. It is small, and a
    // known value keeps the first frame after reset fully deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            slot      <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the pre-edge values computed by the combinational block.
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            q         <= q_nxt;
            q_valid   <= q_valid_nxt;
            slot      <= slot_nxt;
            busy      <= busy_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first. Any path that
        // leaves one unassigned would infer a latch.
        state_nxt     = state;
        shadow_nxt    = shadow;
        q_nxt         = q;
        slot_nxt      = slot;
        busy_nxt      = busy;
        q_valid_nxt   = 1'b0;   // pulses drop back unless re-asserted below
        frame_err_nxt = 1'b0;

        if (din_valid) begin
            case (state)
                IDLE: begin
                    // Bits outside a frame are discarded silently.
                    if (sof) begin
                        shadow_nxt[0] = din;
                        slot_nxt      = SEL_W'(1);
                        busy_nxt      = 1'b1;
                        state_nxt     = COLLECT;
                    end
                end

                COLLECT: begin
                    if (sof) begin
                        // Early sof aborts the partial frame. The sof bit
                        // becomes slot 0 of the new frame.
                        frame_err_nxt = 1'b1;
                        shadow_nxt[0] = din;
                        slot_nxt      = SEL_W'(1);
                    end else begin
                        shadow_nxt[slot] = din;
                        slot_nxt         = slot + SEL_W'(1);   // wraps 15 -> 0
                        if (slot == LAST_SLOT) begin
`ifdef DEMUX_PARITY_EN
                            state_nxt = PARITY;                // busy stays high
`else
                            q_nxt       = {din, shadow[N_CH-2:0]};
                            q_valid_nxt = 1'b1;
                            busy_nxt    = 1'b0;
                            state_nxt   = IDLE;
`endif
                        end
                    end
                end

`ifdef DEMUX_PARITY_EN
                PARITY: begin
                    if (sof) begin
                        frame_err_nxt = 1'b1;
                        shadow_nxt[0] = din;
                        slot_nxt      = SEL_W'(1);
                        state_nxt     = COLLECT;
                    end else begin
                        // Even parity: data bits plus the parity bit have an
                        // even number of ones.
                        if (^{din, shadow} == 1'b0) begin
                            q_nxt       = shadow;
                            q_valid_nxt = 1'b1;
                        end else begin
                            frame_err_nxt = 1'b1;
                        end
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
`endif

                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
